// File: rtl/apu_pkg.sv
// Shared APU constants and types for the noise voice.
package apu_pkg;

    localparam int unsigned APU_PHASE_W     = 32;
    localparam int unsigned APU_ENV_W       = 9;
    localparam int unsigned NOISE_LFSR_W    = 15;
    localparam int unsigned NOISE_TAP_LONG  = 1;
    localparam int unsigned NOISE_TAP_SHORT = 6;

    localparam logic [NOISE_LFSR_W-1:0] NOISE_LFSR_SEED_DEFAULT = 15'h0001;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } noise_state_e;

endpackage

// File: rtl/noise_lfsr.sv
// 15-bit right-shifting noise LFSR with step enable, selectable second tap,
// and automatic reload of the seed if the register ever reaches all-zero.
module noise_lfsr
    import apu_pkg::*;
#(
    parameter logic [NOISE_LFSR_W-1:0] SEED = NOISE_LFSR_SEED_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic                    short_sel,
    output logic [NOISE_LFSR_W-1:0] lfsr
);

    logic fb;

    // Feedback: bit 0 xor the long or short tap.
    always_comb begin
        fb = lfsr[0] ^ (short_sel ? lfsr[NOISE_TAP_SHORT] : lfsr[NOISE_TAP_LONG]);
    end

    // Shift register; all-zero lock-up recovers to the seed regardless of step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (lfsr == '0) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {fb, lfsr[NOISE_LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/channel_4_noise_voice.sv
// Channel-4 noise voice: phase accumulator whose carry clocks a noise LFSR,
// gating the envelope onto a registered sample on each mixer strobe.
// Optional feature: define CH4_NOISE_SHORT_MODE_EN to add i_short_mode
// (short-period LFSR taps); without it only the long sequence exists.
module channel_4_noise_voice
    import apu_pkg::*;
#(
    parameter logic [NOISE_LFSR_W-1:0] LFSR_SEED = NOISE_LFSR_SEED_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [APU_PHASE_W-1:0] i_phase_delta,
    input  logic [APU_ENV_W-1:0]   i_envelope,
    input  logic                   i_sample_stb,
`ifdef CH4_NOISE_SHORT_MODE_EN
    input  logic                   i_short_mode,
`endif
    output logic [APU_ENV_W-1:0]   o_sample,
    output logic                   o_sample_valid
);

    noise_state_e            state;
    logic [APU_PHASE_W-1:0]  acc;
    logic                    carry;
    logic [APU_PHASE_W:0]    sum;
    logic [NOISE_LFSR_W-1:0] lfsr;
    logic                    lfsr_step;
    logic                    short_sel;

    // 33-bit sum: bit 32 becomes the registered carry.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, i_phase_delta};
        lfsr_step = (state == ST_RUN) && carry;
`ifdef CH4_NOISE_SHORT_MODE_EN
        short_sel = i_short_mode;
`else
        short_sel = 1'b0;
`endif
    end

    // Rest/run FSM with the phase accumulator; acc and carry frozen while resting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_phase_delta != '0) begin
                        state <= ST_RUN;
                        acc   <= '0;
                        carry <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_phase_delta == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        {carry, acc} <= sum;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    noise_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (i_clk),
        .rst       (i_rst),
        .step      (lfsr_step),
        .short_sel (short_sel),
        .lfsr      (lfsr)
    );

    // Output register: sample uses pre-edge state/lfsr, holds between strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            o_sample_valid <= i_sample_stb;
            if (i_sample_stb) begin
                o_sample <= ((state == ST_RUN) && !lfsr[0]) ? i_envelope : '0;
            end
        end
    end

endmodule

// File: tb/tb_channel_4_noise_voice.sv
// Self-checking bench for channel_4_noise_voice: cycle model plus directed
// literal checks. Define CH4_NOISE_SHORT_MODE_EN to also cover short mode.
module tb_channel_4_noise_voice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] delta = '0;
    logic [8:0]  env = '0;
    logic        stb = 1'b0;
    logic        short_mode = 1'b0;
    logic [8:0]  sample;
    logic        valid;
    bit          cmp_en = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    channel_4_noise_voice #(
        .LFSR_SEED (15'h0001)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_phase_delta  (delta),
        .i_envelope     (env),
        .i_sample_stb   (stb),
`ifdef CH4_NOISE_SHORT_MODE_EN
        .i_short_mode   (short_mode),
`endif
        .o_sample       (sample),
        .o_sample_valid (valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: running flag, 33-bit phase sum, LFSR sequence.
    bit          m_run   = 1'b0;
    logic [31:0] m_acc   = '0;
    logic        m_carry = 1'b0;
    logic [14:0] m_lfsr  = 15'h0001;
    logic [8:0]  m_sample = '0;
    logic        m_valid = 1'b0;

    function automatic logic [14:0] next_noise(input logic [14:0] v, input logic sm);
        logic fb;
        fb = v[0] ^ (sm ? v[6] : v[1]);
        return {fb, v[14:1]};
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 1'b0; m_acc = '0; m_carry = 1'b0;
                m_lfsr = 15'h0001; m_sample = '0; m_valid = 1'b0;
            end else begin
                logic [32:0] s;
                logic        sm;
`ifdef CH4_NOISE_SHORT_MODE_EN
                sm = short_mode;
`else
                sm = 1'b0;
`endif
                // outputs and noise use values from before this edge
                m_valid = stb;
                if (stb) m_sample = (m_run && (m_lfsr[0] == 1'b0)) ? env : 9'd0;
                if (m_lfsr == 15'd0) m_lfsr = 15'h0001;
                else if (m_run && m_carry) m_lfsr = next_noise(m_lfsr, sm);
                if (!m_run) begin
                    if (delta != 0) begin
                        m_run = 1'b1; m_acc = '0; m_carry = 1'b0;
                    end
                end else if (delta == 0) begin
                    m_run = 1'b0;
                end else begin
                    s = {1'b0, m_acc} + {1'b0, delta};
                    m_acc = s[31:0];
                    m_carry = s[32];
                end
            end
        end
    end

    // Per-cycle compare of DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                check("cyc_sample", 32'(sample), 32'(m_sample));
                check("cyc_valid", 32'(valid), 32'(m_valid));
                check("cyc_lfsr", 32'(dut.u_lfsr.lfsr), 32'(m_lfsr));
                check("cyc_acc", dut.acc, m_acc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        delta = '0;
        stb = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic count_period(input string name, input int exp_steps);
        logic [14:0] prev;
        logic [14:0] cur;
        int          steps;
        prev = dut.u_lfsr.lfsr;
        steps = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            cur = dut.u_lfsr.lfsr;
            if (cur != prev) steps++;
            prev = cur;
            if (cur == 15'h0001 && steps > 0) break;
        end
        check(name, 32'(steps), 32'(exp_steps));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Rest: every strobe gives zero, LFSR frozen at seed
        env = 9'h00B;
        for (int k = 0; k < 4; k++) begin
            repeat (15) @(negedge clk);
            stb = 1'b1;
            @(negedge clk);
            stb = 1'b0;
            check("rest_sample", 32'(sample), 32'h0);
            check("rest_valid", 32'(valid), 32'h1);
            check("rest_lfsr", 32'(dut.u_lfsr.lfsr), 32'h0001);
        end

        // Half-range delta: carry every second RUN clock, steps lag by one
        do_reset();
        @(negedge clk);
        delta = 32'h8000_0000;
        repeat (3) @(negedge clk);
        check("half_lfsr_pre", 32'(dut.u_lfsr.lfsr), 32'h0001);
        @(negedge clk);
        check("half_lfsr_1", 32'(dut.u_lfsr.lfsr), 32'h4000);
        @(negedge clk);
        check("half_lfsr_hold", 32'(dut.u_lfsr.lfsr), 32'h4000);
        @(negedge clk);
        check("half_lfsr_2", 32'(dut.u_lfsr.lfsr), 32'h2000);

        // Strobe coincident with first step, then back-to-back strobes
        do_reset();
        @(negedge clk);
        env = 9'h00B;
        delta = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        check("coinc_sample", 32'(sample), 32'h0);
        check("coinc_valid", 32'(valid), 32'h1);
        check("coinc_lfsr", 32'(dut.u_lfsr.lfsr), 32'h4000);
        @(negedge clk);
        check("b2b_sample_1", 32'(sample), 32'h00B);
        check("b2b_valid_1", 32'(valid), 32'h1);
        @(negedge clk);
        stb = 1'b0;
        check("b2b_sample_2", 32'(sample), 32'h00B);
        check("b2b_valid_2", 32'(valid), 32'h1);
        @(negedge clk);
        check("hold_sample", 32'(sample), 32'h00B);
        check("hold_valid", 32'(valid), 32'h0);

        // Back to rest: strobe gives zero, acc held (model checks acc)
        delta = '0;
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("mute_sample", 32'(sample), 32'h0);
        check("mute_valid", 32'(valid), 32'h1);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a run with a live valid pulse
        delta = 32'hFFFF_FFFF;
        env = 9'h1FF;
        repeat (8) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("pre_rst_sample", 32'(sample), 32'h1FF);
        check("pre_rst_valid", 32'(valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_sample", 32'(sample), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_lfsr", 32'(dut.u_lfsr.lfsr), 32'h0001);
        check("rst_acc", dut.acc, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Full long-mode period
        @(negedge clk);
        delta = 32'hFFFF_FFFF;
        count_period("long_period", 32767);

`ifdef CH4_NOISE_SHORT_MODE_EN
        do_reset();
        @(negedge clk);
        short_mode = 1'b1;
        delta = 32'hFFFF_FFFF;
        count_period("short_period", 93);
        short_mode = 1'b0;
`endif

        do_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
